// File: rtl/dec_mux_add_pipe.sv
// ---------------------------------------------------------------------------
// dec_mux_add_pipe
//
// Two-register pipeline around three small datapaths: a one-hot decoder,
// an NCH-way multiplexer with out-of-range detection, and a W-bit adder
// that can either add two operands or accumulate into an internal register.
//
// Stage 1 captures an accepted transaction's raw inputs. Stage 2 holds the
// computed results, which drive the outputs directly. A single advance
// signal moves both stages together; when the downstream stalls, everything
// (including the accumulator) freezes.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input transaction present
//   in_ready   out  block accepts a transaction this cycle
//   sel1       in   [DECW]      decoder select
//   en         in   decoder enable
//   din        in   [NCH*W]     mux channels, channel k at [k*W +: W]
//   sel2       in   [SELW+1]    mux select, values >= NCH are out of range
//   X, Y       in   [W]         adder operands
//   Ci         in   adder carry-in
//   acc_mode   in   0: S = X+Y+Ci, 1: S = acc+X+Ci
//   acc_clr    in   with acc_mode=1, use 0 in place of acc
//   out_valid  out  result present
//   out_ready  in   downstream accepts result
//   decout     out  [2^DECW]    one-hot decode (0 when disabled)
//   muxout     out  [W]         selected channel (0 when out of range)
//   sel_err    out  sel2 was out of range
//   S          out  [W]         sum modulo 2^W
//   Co         out  carry-out of the sum
// ---------------------------------------------------------------------------
module dec_mux_add_pipe #(
  parameter  int DECW = 4,
  parameter  int NCH  = 4,
  parameter  int W    = 4,
  localparam int SELW = $clog2(NCH),
  localparam int DECN = 1 << DECW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DECW-1:0]   sel1,
  input  logic              en,
  input  logic [NCH*W-1:0]  din,
  input  logic [SELW:0]     sel2,
  input  logic [W-1:0]      X,
  input  logic [W-1:0]      Y,
  input  logic              Ci,
  input  logic              acc_mode,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DECN-1:0]   decout,
  output logic [W-1:0]      muxout,
  output logic              sel_err,
  output logic [W-1:0]      S,
  output logic              Co
);

  // Stage 1: raw captured inputs of the transaction in flight
  logic              s1Valid_q;
  logic [DECW-1:0]   s1Sel1_q;
  logic              s1En_q;
  logic [NCH*W-1:0]  s1Din_q;
  logic [SELW:0]     s1Sel2_q;
  logic [W-1:0]      s1X_q;
  logic [W-1:0]      s1Y_q;
  logic              s1Ci_q;
  logic              s1Mode_q;
  logic              s1Clr_q;

  // Stage 2: computed results, driven straight onto the outputs
  logic              outValid_q;
  logic [DECN-1:0]   decout_q;
  logic [W-1:0]      muxout_q;
  logic              selErr_q;
  logic [W-1:0]      sum_q;
  logic              co_q;

  // Running accumulator, only touched by mode-1 results entering stage 2
  logic [W-1:0]      acc_q;

  // Next-state values for stage 2, computed from stage 1
  logic [DECN-1:0]   decout_d;
  logic [W-1:0]      muxout_d;
  logic              selErr_d;
  logic [W-1:0]      addA_d;
  logic [W:0]        sum_d;

  logic              advance;

  // The pipeline moves whenever the output slot is empty or being drained.
  // Both stages share this single enable, so a stall freezes everything.
  assign advance  = !outValid_q || out_ready;
  assign in_ready = advance;

  assign out_valid = outValid_q;
  assign decout    = decout_q;
  assign muxout    = muxout_q;
  assign sel_err   = selErr_q;
  assign S         = sum_q;
  assign Co        = co_q;

  // Result logic for the transaction sitting in stage 1.
  // The accumulator operand is read straight from acc_q: a preceding mode-1
  // result updates acc_q on the very edge it enters stage 2, which is the
  // same edge that brings the next transaction into stage 1, so the
  // following transaction always sees the fresh value without forwarding
  // muxes.
  always_comb begin
    decout_d = '0;
    if (s1En_q) begin
      decout_d[s1Sel1_q] = 1'b1;
    end

    muxout_d = '0;
    selErr_d = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (s1Sel2_q == (SELW+1)'(k)) begin
        muxout_d = s1Din_q[k*W +: W];
        selErr_d = 1'b0;
      end
    end

    if (!s1Mode_q) begin
      addA_d = s1Y_q;
    end else if (s1Clr_q) begin
      addA_d = '0;
    end else begin
      addA_d = acc_q;
    end

    sum_d = {1'b0, addA_d} + {1'b0, s1X_q} + {{W{1'b0}}, s1Ci_q};
  end

  // Stage 1 capture. The valid bit follows in_valid on every advance so
  // bubbles propagate, but the data fields are only loaded for a real
  // transaction; idle-cycle garbage on the inputs never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Sel1_q  <= '0;
      s1En_q    <= 1'b0;
      s1Din_q   <= '0;
      s1Sel2_q  <= '0;
      s1X_q     <= '0;
      s1Y_q     <= '0;
      s1Ci_q    <= 1'b0;
      s1Mode_q  <= 1'b0;
      s1Clr_q   <= 1'b0;
    end else if (advance) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Sel1_q <= sel1;
        s1En_q   <= en;
        s1Din_q  <= din;
        s1Sel2_q <= sel2;
        s1X_q    <= X;
        s1Y_q    <= Y;
        s1Ci_q   <= Ci;
        s1Mode_q <= acc_mode;
        s1Clr_q  <= acc_clr;
      end
    end
  end

  // Stage 2 and accumulator. A bubble clears out_valid but leaves the data
  // outputs at their previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      decout_q   <= '0;
      muxout_q   <= '0;
      selErr_q   <= 1'b0;
      sum_q      <= '0;
      co_q       <= 1'b0;
      acc_q      <= '0;
    end else if (advance) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        decout_q <= decout_d;
        muxout_q <= muxout_d;
        selErr_q <= selErr_d;
        sum_q    <= sum_d[W-1:0];
        co_q     <= sum_d[W];
        if (s1Mode_q) begin
          acc_q <= sum_d[W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_mux_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_dec_mux_add_pipe
//
// Self-checking bench for dec_mux_add_pipe at default parameters.
// Directed cases for the documented examples (single op, out-of-range
// select, accumulate chain, stall, mid-stream reset) followed by random
// traffic with random in_valid/out_ready, all compared against an
// arithmetic reference model and an in-order scoreboard queue.
// ---------------------------------------------------------------------------
module tb_dec_mux_add_pipe;

  localparam int DECW = 4;
  localparam int NCH  = 4;
  localparam int W    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel1;
  logic        en;
  logic [15:0] din;
  logic [2:0]  sel2;
  logic [3:0]  X;
  logic [3:0]  Y;
  logic        Ci;
  logic        acc_mode;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] decout;
  logic [3:0]  muxout;
  logic        sel_err;
  logic [3:0]  S;
  logic        Co;

  typedef struct packed {
    logic [3:0]  sel1;
    logic        en;
    logic [15:0] din;
    logic [2:0]  sel2;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        ci;
    logic        mode;
    logic        clr;
  } txn_t;

  typedef struct packed {
    logic [15:0] decout;
    logic [3:0]  muxout;
    logic        selErr;
    logic [3:0]  s;
    logic        co;
  } res_t;

  int   checkCount = 0;
  int   failCount  = 0;
  int   modelAcc   = 0;
  res_t expQ[$];
  logic prevStall  = 1'b0;
  res_t prevRes    = '0;
  res_t obsRes;
  logic obsValid;
  logic obsReady;

  dec_mux_add_pipe #(.DECW(DECW), .NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel1      (sel1),
    .en        (en),
    .din       (din),
    .sel2      (sel2),
    .X         (X),
    .Y         (Y),
    .Ci        (Ci),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .decout    (decout),
    .muxout    (muxout),
    .sel_err   (sel_err),
    .S         (S),
    .Co        (Co)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Behavioural reference: plain arithmetic on the transaction fields
  function automatic res_t refModel(input txn_t t, input int accIn);
    res_t r;
    int   a;
    int   total;
    r.decout = t.en ? 16'(1 << t.sel1) : 16'h0000;
    if (int'(t.sel2) < NCH) begin
      r.muxout = 4'((int'(t.din) >> (int'(t.sel2) * W)) % 16);
      r.selErr = 1'b0;
    end else begin
      r.muxout = 4'h0;
      r.selErr = 1'b1;
    end
    if (!t.mode)     a = int'(t.y);
    else if (t.clr)  a = 0;
    else             a = accIn;
    total = a + int'(t.x) + int'(t.ci);
    r.s   = 4'(total % 16);
    r.co  = (total >= 16);
    return r;
  endfunction

  function automatic txn_t mkTxn(input int s1, input int e, input int d, input int s2,
                                 input int x, input int y, input int c,
                                 input int m, input int cl);
    txn_t t;
    t.sel1 = 4'(s1);  t.en = 1'(e);  t.din = 16'(d);  t.sel2 = 3'(s2);
    t.x = 4'(x);  t.y = 4'(y);  t.ci = 1'(c);  t.mode = 1'(m);  t.clr = 1'(cl);
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    t.sel1 = 4'($urandom_range(0, 15));
    t.en   = 1'($urandom_range(0, 1));
    t.din  = 16'($urandom_range(0, 65535));
    t.sel2 = 3'($urandom_range(0, 7));
    t.x    = 4'($urandom_range(0, 15));
    t.y    = 4'($urandom_range(0, 15));
    t.ci   = 1'($urandom_range(0, 1));
    t.mode = 1'($urandom_range(0, 1));
    t.clr  = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  task automatic applyStimulus(input txn_t t, input logic inValid, input logic outReady);
    in_valid  = inValid;
    out_ready = outReady;
    sel1      = t.sel1;
    en        = t.en;
    din       = t.din;
    sel2      = t.sel2;
    X         = t.x;
    Y         = t.y;
    Ci        = t.ci;
    acc_mode  = t.mode;
    acc_clr   = t.clr;
  endtask

  // One clock cycle: drive at the falling edge, sample and score, then let
  // the rising edge commit whatever transfers the handshakes allow.
  task automatic runCycle(input txn_t t, input logic inValid, input logic outReady);
    res_t expRes;
    @(negedge clk);
    applyStimulus(t, inValid, outReady);
    #1;
    obsValid = out_valid;
    obsReady = in_ready;
    obsRes   = {decout, muxout, sel_err, S, Co};
    checkOutput("in_ready", 64'(in_ready), 64'(!out_valid || outReady));
    if (prevStall) begin
      checkOutput("stall_valid", 64'(out_valid), 64'(1));
      checkOutput("stall_hold", 64'(obsRes), 64'(prevRes));
    end
    if (out_valid && outReady) begin
      checkOutput("sb_nonempty", 64'(expQ.size() != 0), 64'(1));
      if (expQ.size() != 0) begin
        expRes = expQ.pop_front();
        checkOutput("sb_result", 64'(obsRes), 64'(expRes));
      end
    end
    if (inValid && in_ready) begin
      expRes = refModel(t, modelAcc);
      if (t.mode) modelAcc = int'(expRes.s);
      expQ.push_back(expRes);
    end
    checkOutput("occupancy", 64'(expQ.size() <= 2), 64'(1));
    prevStall = out_valid && !outReady;
    prevRes   = obsRes;
  endtask

  txn_t idle;

  initial begin
    idle  = '0;
    rst_n = 1'b1;
    applyStimulus(idle, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #11;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_outputs", 64'({decout, muxout, sel_err, S, Co}), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Single op, accepted on the first edge after reset release
    runCycle(mkTxn(5, 1, 16'h0A00, 2, 9, 8, 1, 0, 0), 1'b1, 1'b1);
    runCycle(idle, 1'b0, 1'b1);
    checkOutput("lat_one_cycle", 64'(obsValid), 64'(0));
    runCycle(idle, 1'b0, 1'b1);
    checkOutput("lat_two_valid", 64'(obsValid), 64'(1));
    checkOutput("single_op", 64'(obsRes), 64'({16'h0020, 4'hA, 1'b0, 4'h2, 1'b1}));

    // Out-of-range select with decoder disabled
    runCycle(mkTxn(7, 0, 16'hFFFF, 6, 1, 2, 0, 0, 0), 1'b1, 1'b1);
    runCycle(idle, 1'b0, 1'b1);
    runCycle(idle, 1'b0, 1'b1);
    checkOutput("oor_decout", 64'(obsRes.decout), 64'(0));
    checkOutput("oor_muxout", 64'(obsRes.muxout), 64'(0));
    checkOutput("oor_sel_err", 64'(obsRes.selErr), 64'(1));

    // Back-to-back accumulate chain: 3, 8, 7 with carries 0, 0, 1
    runCycle(mkTxn(0, 0, 0, 0, 3, 0, 0, 1, 1), 1'b1, 1'b1);
    runCycle(mkTxn(0, 0, 0, 0, 4, 0, 1, 1, 0), 1'b1, 1'b1);
    runCycle(mkTxn(0, 0, 0, 0, 15, 0, 0, 1, 0), 1'b1, 1'b1);
    checkOutput("acc_first", 64'({obsValid, obsRes.s, obsRes.co}), 64'({1'b1, 4'd3, 1'b0}));
    runCycle(idle, 1'b0, 1'b1);
    checkOutput("acc_second", 64'({obsValid, obsRes.s, obsRes.co}), 64'({1'b1, 4'd8, 1'b0}));
    runCycle(idle, 1'b0, 1'b1);
    checkOutput("acc_third", 64'({obsValid, obsRes.s, obsRes.co}), 64'({1'b1, 4'd7, 1'b1}));
    runCycle(idle, 1'b0, 1'b1);

    // Stall with both stages full for three cycles, then release
    runCycle(mkTxn(1, 1, 16'h1234, 1, 2, 0, 0, 1, 1), 1'b1, 1'b1);
    runCycle(mkTxn(2, 1, 16'h5678, 3, 5, 0, 0, 1, 0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      runCycle(mkTxn(3, 1, 16'h9ABC, 0, 1, 0, 1, 1, 0), 1'b1, 1'b0);
      checkOutput("stall_in_ready", 64'(obsReady), 64'(0));
    end
    runCycle(mkTxn(3, 1, 16'h9ABC, 0, 1, 0, 1, 1, 0), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) runCycle(idle, 1'b0, 1'b1);
    checkOutput("stall_drained", 64'(expQ.size()), 64'(0));

    // Mid-stream reset with both stages holding transactions
    runCycle(mkTxn(4, 1, 16'h4321, 1, 6, 0, 0, 1, 1), 1'b1, 1'b0);
    runCycle(mkTxn(6, 1, 16'h1111, 2, 9, 0, 0, 1, 0), 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("mid_rst_outputs", 64'({decout, muxout, sel_err, S, Co}), 64'(0));
    expQ.delete();
    modelAcc  = 0;
    prevStall = 1'b0;
    applyStimulus(idle, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      runCycle(idle, 1'b0, 1'b1);
      checkOutput("post_rst_no_output", 64'(obsValid), 64'(0));
    end
    runCycle(mkTxn(0, 0, 0, 0, 5, 0, 0, 1, 0), 1'b1, 1'b1);
    runCycle(idle, 1'b0, 1'b1);
    runCycle(idle, 1'b0, 1'b1);
    checkOutput("post_rst_acc", 64'({obsValid, obsRes.s, obsRes.co}), 64'({1'b1, 4'd5, 1'b0}));

    // Random traffic; idle cycles carry random garbage on every input
    for (int i = 0; i < 3000; i++) begin
      runCycle(randTxn(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) runCycle(randTxn(), 1'b0, 1'b1);
    checkOutput("final_drain", 64'(expQ.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
